// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - period codes, island FSM states and data-island timing constants
package h14tx_pkg;

  typedef enum logic [2:0] {
    Control       = 3'd0,
    VideoActive   = 3'd1,
    VideoPreamble = 3'd2,
    VideoGuard    = 3'd3,
    DataPreamble  = 3'd4,
    DataGuard     = 3'd5,
    DataActive    = 3'd6
  } period_t;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StLeadGuard,
    StPacket,
    StTrailGuard
  } island_state_t;

  localparam int IslandPreambleLen = 8;
  localparam int IslandGuardLen    = 2;
  localparam int PacketLen         = 32;

endpackage

// File: rtl/h14tx_rr_arbiter.sv
// rtl/h14tx_rr_arbiter.sv - combinational round-robin search starting at ptr, one-hot grant
module h14tx_rr_arbiter #(
  parameter int NumReq = 4,
  parameter int SelW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [SelW-1:0]   ptr,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] grant
);

  logic [2*NumReq-1:0] reqRot;
  logic [2*NumReq-1:0] grantUnrot;
  logic [NumReq-1:0]   grantRot;
  logic                found;

  // Rotate so that index ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    reqRot   = {req, req} >> ptr;
    grantRot = '0;
    found    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && reqRot[i]) begin
        grantRot[i] = 1'b1;
        found       = 1'b1;
      end
    end
    grantUnrot = {grantRot, grantRot} << ptr;
    grant      = grantUnrot[2*NumReq-1:NumReq];
  end

endmodule

// File: rtl/h14tx_island_scheduler.sv
// rtl/h14tx_island_scheduler.sv - data-island sequencer and packet slot arbiter in horizontal blanking
// Optional: H14TX_ISLAND_VBLANK_ONLY_EN restricts islands to vertical-blanking lines.
module h14tx_island_scheduler
  import h14tx_pkg::*;
#(
  parameter int BitWidth     = 11,
  parameter int BitHeight    = 10,
  parameter int FrameWidth   = 1650,
  parameter int FrameHeight  = 750,
  parameter int ActiveWidth  = 1280,
  parameter int ActiveHeight = 720,
  parameter int NumReq       = 4,
  parameter int MaxPackets   = 18,
  parameter int ControlGap   = 4,
  localparam int SelW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic [NumReq-1:0]    req,
  output logic [NumReq-1:0]    grant,
  output period_t              island,
  output logic [SelW-1:0]      pkt_sel,
  output logic [4:0]           pkt_word
);

  localparam int IslandStart = ActiveWidth + ControlGap;
  localparam int IslandLimit = FrameWidth - 10 - ControlGap;
  localparam int SlotLen     = PacketLen + IslandGuardLen;
  localparam bit StartFits   = (IslandStart + IslandPreambleLen + IslandGuardLen + SlotLen) <= IslandLimit;
`ifdef H14TX_ISLAND_VBLANK_ONLY_EN
  localparam bit VblankOnly  = 1'b1;
`else
  localparam bit VblankOnly  = 1'b0;
`endif

  island_state_t     stateQ, stateD;
  logic [4:0]        cntQ, cntD;
  logic [4:0]        pktCntQ, pktCntD;
  logic [SelW-1:0]   ownerQ, ownerD;
  logic [SelW-1:0]   ptrQ, ptrD;
  logic [NumReq-1:0] arbGrant;
  logic [SelW-1:0]   arbIdx;
  logic              lineOk, startOk, slotOk;
  period_t           islandD;
  logic [NumReq-1:0] grantD;
  logic [4:0]        wordD;

  h14tx_rr_arbiter #(
    .NumReq (NumReq),
    .SelW   (SelW)
  ) u_arb (
    .ptr   (ptrQ),
    .req   (req),
    .grant (arbGrant)
  );

  always_comb begin
    arbIdx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (arbGrant[i]) arbIdx = SelW'(i);
    end
  end

  assign lineOk  = (int'(y) < FrameHeight) && (!VblankOnly || int'(y) >= ActiveHeight);
  assign startOk = StartFits && lineOk && (req != '0) && (int'(x) == IslandStart - 1);
  // x + 1 is where word 0 of the would-be packet lands; it plus its trail guard must fit.
  assign slotOk  = (req != '0) && (int'(pktCntQ) < MaxPackets)
                && (int'(x) + 1 + SlotLen <= IslandLimit);

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ + 5'd1;
    pktCntD = pktCntQ;
    ownerD  = ownerQ;
    ptrD    = ptrQ;
    unique case (stateQ)
      StIdle: begin
        cntD    = '0;
        pktCntD = '0;
        if (startOk) stateD = StPreamble;
      end
      StPreamble: begin
        if (int'(cntQ) == IslandPreambleLen - 1) begin
          stateD = StLeadGuard;
          cntD   = '0;
        end
      end
      StLeadGuard, StPacket: begin
        if ((stateQ == StLeadGuard && int'(cntQ) == IslandGuardLen - 1) ||
            (stateQ == StPacket && int'(cntQ) == PacketLen - 1)) begin
          cntD = '0;
          if (slotOk) begin
            stateD  = StPacket;
            ownerD  = arbIdx;
            ptrD    = (arbIdx == SelW'(NumReq - 1)) ? '0 : arbIdx + SelW'(1);
            pktCntD = pktCntQ + 5'd1;
          end else begin
            stateD = StTrailGuard;
          end
        end
      end
      StTrailGuard: begin
        if (int'(cntQ) == IslandGuardLen - 1) begin
          stateD = StIdle;
          cntD   = '0;
        end
      end
      default: begin
        stateD = StIdle;
        cntD   = '0;
      end
    endcase
  end

  always_comb begin
    islandD = Control;
    grantD  = '0;
    wordD   = '0;
    unique case (stateQ)
      StPreamble:                islandD = DataPreamble;
      StLeadGuard, StTrailGuard: islandD = DataGuard;
      StPacket: begin
        islandD = DataActive;
        wordD   = cntQ;
        if (cntQ == 5'd0) grantD = NumReq'(1) << ownerQ;
      end
      default:                   islandD = Control;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      pktCntQ  <= '0;
      ownerQ   <= '0;
      ptrQ     <= '0;
      island   <= Control;
      grant    <= '0;
      pkt_sel  <= '0;
      pkt_word <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      pktCntQ  <= pktCntD;
      ownerQ   <= ownerD;
      ptrQ     <= ptrD;
      island   <= islandD;
      grant    <= grantD;
      pkt_sel  <= ownerQ;
      pkt_word <= wordD;
    end
  end

endmodule
